ahb_mst_ctrl: RTL and testbench

AHB-Lite initiator that turns simple command requests into pipelined word transfers on the AHB bus feeding the SRAM subsystem's slave interface. It drives the address/control/write-data side of the bus and consumes `hready`/`hresp`/`hrdata` back from the slave. It handles wait states, write-data underrun and ERROR responses. Together with the SRAM slave it forms a closed loop that requires no external bus master, e.g. for self-test and preload.

---
 rtl/ahb_mst_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ahb_mst_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mst_ctrl.sv
// AHB-Lite word-transfer initiator: turns command requests into pipelined
// NONSEQ/SEQ beats with wait-state, write-underrun (BUSY) and ERROR handling.
module ahb_mst_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             hclk,
  input  logic             hrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [31:0]      wdat,
  output logic             rdat_valid,
  output logic [31:0]      rdat,
  output logic             done,
  output logic             err,
  output logic             hsel,
  output logic [1:0]       htrans,
  output logic [31:0]      haddr,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [2:0]       hburst,
  output logic [31:0]      hwdata,
  input  logic             hready,
  input  logic [1:0]       hresp,
  input  logic [31:0]      hrdata
);

  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_LAST = 2'd2, S_ERR = 2'd3;
  localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000, BURST_INCR = 3'b001;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef struct packed {
    logic             write;
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
  } cmd_t;

  logic [1:0]       state;
  logic [1:0]       trans_q;   // beat type to present once data is available
  logic [LEN_W-1:0] rem;       // beats still owed an address phase, incl. current
  logic             first;
  logic             dph;
  logic             dph_write;

  cmd_t        cmd_c;
  logic [31:0] haddr_nxt;
  logic        hold_wr;
  logic        err_hit;
  logic        addr_done;
  logic        data_ok;
  logic        cmd_fire;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];
  assign hsize           = 3'b010;
  assign haddr_nxt       = haddr + 32'd4;

  always_comb begin
    cmd_c.write = cmd_write;
    cmd_c.addr  = {cmd_addr[31:2], 2'b00};
    cmd_c.len   = cmd_len;
    if (cmd_len == '0)
      cmd_c.len = LEN_ONE;
    else if (cmd_len > LEN_MAX)
      cmd_c.len = LEN_MAX;
  end

  // A write beat is only put on the bus while its word is offered; until then
  // the first beat shows IDLE and later beats show BUSY at the pending address.
  always_comb begin
    hold_wr = (state == S_ADDR) && hwrite && !wdat_valid;
    htrans  = trans_q;
    if (hold_wr && trans_q != TR_IDLE)
      htrans = first ? TR_IDLE : TR_BUSY;
  end

  always_comb begin
    err_hit    = dph && (hresp != 2'b00) && (state != S_ERR);
    addr_done  = (state == S_ADDR) && htrans[1] && hready && !err_hit;
    data_ok    = dph && hready && !err_hit && (state != S_ERR);
    wdat_ready = addr_done && hwrite;
    rdat_valid = data_ok && !dph_write;
    rdat       = rdat_valid ? hrdata : 32'd0;
    done       = ((state == S_LAST) && data_ok) || (state == S_ERR);
    err        = (state == S_ERR);
    cmd_ready  = (state == S_IDLE) || done;
    cmd_fire   = cmd_valid && cmd_ready;
    hsel       = (htrans != TR_IDLE) || dph;
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state     <= S_IDLE;
      trans_q   <= TR_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hburst    <= BURST_SINGLE;
      hwdata    <= '0;
      rem       <= '0;
      first     <= 1'b0;
      dph       <= 1'b0;
      dph_write <= 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (err_hit) begin
            state   <= S_ERR;
            trans_q <= TR_IDLE;
          end else if (hready) begin
            dph <= addr_done;
            if (addr_done) begin
              dph_write <= hwrite;
              if (hwrite)
                hwdata <= wdat;
              if (rem == LEN_ONE) begin
                trans_q <= TR_IDLE;
                state   <= S_LAST;
              end else begin
                rem     <= rem - LEN_ONE;
                haddr   <= haddr_nxt;
                first   <= 1'b0;
                // crossing a 1 KB boundary restarts the burst
                trans_q <= (haddr_nxt[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
              end
            end
          end
        end
        S_LAST: begin
          if (err_hit) begin
            state <= S_ERR;
          end else if (hready) begin
            dph   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ERR: begin
          dph   <= 1'b0;
          state <= S_IDLE;
        end
        default: ;
      endcase

      // accepting in the done cycle overrides the return to IDLE
      if (cmd_fire) begin
        state   <= S_ADDR;
        trans_q <= TR_NONSEQ;
        haddr   <= cmd_c.addr;
        hwrite  <= cmd_c.write;
        hburst  <= (cmd_c.len > LEN_ONE) ? BURST_INCR : BURST_SINGLE;
        rem     <= cmd_c.len;
        first   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mst_ctrl.sv
// Scoreboard bench for ahb_mst_ctrl with a small AHB slave model that can
// insert wait states or an ERROR response at a chosen data-phase address.
module tb_ahb_mst_ctrl;
  localparam logic [31:0] NONE = 32'hFFFF_FFF0;
  localparam logic [1:0]  NS = 2'b10, SQ = 2'b11, BZ = 2'b01;

  logic        hclk = 1'b0;
  logic        hrst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat;
  logic        rdat_valid;
  logic [31:0] rdat;
  logic        done, err, hsel, hwrite;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  always #5 hclk = ~hclk;

  ahb_mst_ctrl #(.MAX_LEN(16), .LEN_W(5)) dut (
    .hclk(hclk), .hrst(hrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat(rdat), .done(done), .err(err),
    .hsel(hsel), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  burst;
  } aph_t;

  aph_t        exp_aph[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wd[$];
  logic        exp_err[$];
  int          exp_lat[$];
  int          acc_q[$];
  logic [31:0] wq[$];
  int          wg[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, wr_cnt = 0, b2b_cnt = 0, gap_cnt = 0;

  function automatic aph_t mk(input logic [1:0] t, input logic [31:0] a,
                              input logic w, input logic [2:0] b);
    return {t, a, w, b};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an event or timeout, want none", name);
  endtask

  // slave model: data phase tracking, wait states, two-cycle ERROR
  logic        dp_valid, dp_write, errbeat, stall;
  logic [31:0] dp_addr;
  logic [31:0] stall_addr = NONE, err_addr = NONE;
  int          stall_n = 0, wcnt, ecnt;

  always_comb begin
    errbeat = dp_valid && dp_addr == err_addr;
    stall   = dp_valid && dp_addr == stall_addr && wcnt < stall_n;
    hready  = errbeat ? (ecnt == 1) : !stall;
    hresp   = errbeat ? 2'b01 : 2'b00;
    hrdata  = {16'hC0DE, dp_addr[15:0]};
  end

  always @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      dp_valid <= 1'b0; dp_write <= 1'b0; dp_addr <= '0; wcnt <= 0; ecnt <= 0;
    end else if (hready) begin
      wcnt <= 0; ecnt <= 0;
      dp_valid <= htrans[1]; dp_addr <= haddr; dp_write <= hwrite;
    end else begin
      wcnt <= wcnt + 1; ecnt <= ecnt + 1;
    end
  end

  initial forever @(posedge hclk) cyc++;

  // write-data source: each queued word may be preceded by a gap of idle cycles
  initial begin : feeder
    logic fire;
    wdat_valid = 1'b0;
    wdat = '0;
    forever begin
      @(negedge hclk);
      fire = wdat_valid && wdat_ready && !hrst;
      @(posedge hclk); #1;
      if (fire && wq.size() > 0) begin
        void'(wq.pop_front());
        void'(wg.pop_front());
        gap_cnt = (wg.size() > 0) ? wg[0] : 0;
      end
      if (wq.size() > 0 && gap_cnt == 0) begin
        wdat_valid = 1'b1;
        wdat = wq[0];
      end else begin
        wdat_valid = 1'b0;
        if (gap_cnt > 0) gap_cnt--;
      end
    end
  end

  // monitor / scoreboard
  initial begin : mon
    aph_t        cur, e;
    logic [31:0] d;
    logic [69:0] prev_snap;
    logic        prev_wait;
    int          lat, a;
    logic        ee;
    prev_wait = 1'b0;
    prev_snap = '0;
    forever begin
      @(negedge hclk);
      if (hrst) begin
        prev_wait = 1'b0;
      end else begin
        cur = mk(htrans, haddr, hwrite, hburst);
        chk("hsel", hsel, (htrans != 2'b00) || dp_valid);
        chk("hsize", hsize, 3'b010);
        if (prev_wait) chk("wait_hold", {cur, hwdata}, prev_snap);
        prev_wait = !hready && hresp == 2'b00 && (htrans != 2'b00 || dp_valid);
        prev_snap = {cur, hwdata};
        if (htrans != 2'b00 && hready) begin
          if (exp_aph.size() == 0) bad("addr_phase_extra");
          else begin e = exp_aph.pop_front(); chk("addr_phase", cur, e); end
        end
        if (dp_valid && dp_write && hready && hresp == 2'b00) begin
          if (exp_wd.size() == 0) bad("hwdata_extra");
          else begin d = exp_wd.pop_front(); chk("hwdata", hwdata, d); end
        end
        if (rdat_valid) begin
          if (exp_rd.size() == 0) bad("rdat_extra");
          else begin d = exp_rd.pop_front(); chk("rdat", rdat, d); end
        end
        if (wdat_ready) begin
          wr_cnt++;
          chk("wdat_valid_at_ready", wdat_valid, 1'b1);
        end
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (done) begin
          done_cnt++;
          if (cmd_valid && cmd_ready) b2b_cnt++;
          if (exp_err.size() == 0 || acc_q.size() == 0) bad("done_extra");
          else begin
            ee = exp_err.pop_front(); lat = exp_lat.pop_front(); a = acc_q.pop_front();
            chk("done_err", err, ee);
            chk("done_latency", cyc - a, lat);
            if (ee) chk("htrans_idle_err2", htrans, 2'b00);
          end
        end else if (err) bad("err_without_done");
      end
    end
  end

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [4:0] l);
    int n;
    n = 0;
    @(posedge hclk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    while (1) begin
      @(negedge hclk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin bad("cmd_accept_timeout"); break; end
    end
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (done_cnt < tgt) begin
      @(negedge hclk);
      n++;
      if (n > 500) begin bad("done_timeout"); break; end
    end
    @(posedge hclk); #1;
  endtask

  task automatic drained(input string name);
    chk({name, "_aph_left"}, exp_aph.size(), 0);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_wd_left"}, exp_wd.size(), 0);
    chk({name, "_done_left"}, exp_err.size(), 0);
  endtask

  task automatic exp_done(input logic e, input int lat);
    exp_err.push_back(e);
    exp_lat.push_back(lat);
  endtask

  initial begin : main
    int base, w0, b0;
    hrst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_bus", {htrans, haddr, hwrite, hburst, hwdata, hsel}, '0);
    chk("rst_hsize", hsize, 3'b010);
    chk("rst_flags", {wdat_ready, rdat_valid, rdat, done, err}, '0);
    @(posedge hclk); #1;
    hrst = 1'b0;

    // single write, zero wait
    base = done_cnt; w0 = wr_cnt;
    wq.push_back(32'hDEADBEEF); wg.push_back(0);
    exp_aph.push_back(mk(NS, 32'h10, 1'b1, 3'b000));
    exp_wd.push_back(32'hDEADBEEF);
    exp_done(1'b0, 2);
    do_cmd(1'b1, 32'h10, 5'd1);
    wait_done(base + 1);
    chk("t1_wdat_ready_cnt", wr_cnt - w0, 1);
    drained("t1");

    // 4-beat read from 0x100, two wait states on beat 2
    base = done_cnt;
    stall_addr = 32'h104; stall_n = 2;
    exp_aph.push_back(mk(NS, 32'h100, 1'b0, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h104, 1'b0, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h108, 1'b0, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h10C, 1'b0, 3'b001));
    exp_rd.push_back(32'hC0DE0100); exp_rd.push_back(32'hC0DE0104);
    exp_rd.push_back(32'hC0DE0108); exp_rd.push_back(32'hC0DE010C);
    exp_done(1'b0, 7);
    do_cmd(1'b0, 32'h102, 5'd4);
    wait_done(base + 1);
    stall_addr = NONE;
    drained("t2");

    // 3-beat write, data absent for 2 cycles before beat 2
    base = done_cnt; w0 = wr_cnt;
    wq.push_back(32'h11111111); wg.push_back(0);
    wq.push_back(32'h22222222); wg.push_back(2);
    wq.push_back(32'h33333333); wg.push_back(0);
    exp_aph.push_back(mk(NS, 32'h20, 1'b1, 3'b001));
    exp_aph.push_back(mk(BZ, 32'h24, 1'b1, 3'b001));
    exp_aph.push_back(mk(BZ, 32'h24, 1'b1, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h24, 1'b1, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h28, 1'b1, 3'b001));
    exp_wd.push_back(32'h11111111); exp_wd.push_back(32'h22222222);
    exp_wd.push_back(32'h33333333);
    exp_done(1'b0, 6);
    do_cmd(1'b1, 32'h20, 5'd3);
    wait_done(base + 1);
    chk("t3_wdat_ready_cnt", wr_cnt - w0, 3);
    drained("t3");

    // 4-beat write across the 1 KB boundary
    base = done_cnt; w0 = wr_cnt;
    wq.push_back(32'hA0A0A0A0); wg.push_back(0);
    wq.push_back(32'hA1A1A1A1); wg.push_back(0);
    wq.push_back(32'hA2A2A2A2); wg.push_back(0);
    wq.push_back(32'hA3A3A3A3); wg.push_back(0);
    exp_aph.push_back(mk(NS, 32'h3F8, 1'b1, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h3FC, 1'b1, 3'b001));
    exp_aph.push_back(mk(NS, 32'h400, 1'b1, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h404, 1'b1, 3'b001));
    exp_wd.push_back(32'hA0A0A0A0); exp_wd.push_back(32'hA1A1A1A1);
    exp_wd.push_back(32'hA2A2A2A2); exp_wd.push_back(32'hA3A3A3A3);
    exp_done(1'b0, 5);
    do_cmd(1'b1, 32'h3F8, 5'd4);
    wait_done(base + 1);
    chk("t4_wdat_ready_cnt", wr_cnt - w0, 4);
    drained("t4");

    // ERROR on beat 2 of an 8-beat read
    base = done_cnt;
    err_addr = 32'h204;
    exp_aph.push_back(mk(NS, 32'h200, 1'b0, 3'b001));
    exp_aph.push_back(mk(SQ, 32'h204, 1'b0, 3'b001));
    exp_rd.push_back(32'hC0DE0200);
    exp_done(1'b1, 4);
    do_cmd(1'b0, 32'h200, 5'd8);
    wait_done(base + 1);
    err_addr = NONE;
    drained("t5");

    // back-to-back singles; second uses len 0 (treated as 1)
    base = done_cnt; b0 = b2b_cnt;
    exp_aph.push_back(mk(NS, 32'h40, 1'b0, 3'b000));
    exp_aph.push_back(mk(NS, 32'h44, 1'b0, 3'b000));
    exp_rd.push_back(32'hC0DE0040); exp_rd.push_back(32'hC0DE0044);
    exp_done(1'b0, 2); exp_done(1'b0, 2);
    do_cmd(1'b0, 32'h40, 5'd1);
    do_cmd(1'b0, 32'h44, 5'd0);
    wait_done(base + 2);
    chk("t6_accept_in_done_cycle", b2b_cnt - b0, 1);
    drained("t6");

    // len 31 clamps to 16 beats
    base = done_cnt;
    for (int i = 0; i < 16; i++) begin
      exp_aph.push_back(mk((i == 0) ? NS : SQ, 32'h500 + 32'(4 * i), 1'b0, 3'b001));
      exp_rd.push_back(32'hC0DE0500 + 32'(4 * i));
    end
    exp_done(1'b0, 17);
    do_cmd(1'b0, 32'h500, 5'd31);
    wait_done(base + 1);
    drained("t7");

    // reset in the middle of an 8-beat read
    base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_aph.push_back(mk((i == 0) ? NS : SQ, 32'h600 + 32'(4 * i), 1'b0, 3'b001));
      exp_rd.push_back(32'hC0DE0600 + 32'(4 * i));
    end
    do_cmd(1'b0, 32'h600, 5'd8);
    repeat (2) @(posedge hclk);
    #1;
    hrst = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_bus", {htrans, haddr, hwrite, hburst, hwdata, hsel}, '0);
    chk("midrst_flags", {wdat_ready, rdat_valid, rdat, done, err}, '0);
    exp_aph.delete(); exp_rd.delete(); exp_wd.delete();
    exp_err.delete(); exp_lat.delete(); acc_q.delete();
    wq.delete(); wg.delete(); gap_cnt = 0;
    repeat (2) @(posedge hclk);
    #1;
    hrst = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    chk("midrst_no_done", done_cnt, base);
    exp_aph.push_back(mk(NS, 32'h60C, 1'b0, 3'b000));
    exp_rd.push_back(32'hC0DE060C);
    exp_done(1'b0, 2);
    do_cmd(1'b0, 32'h60C, 5'd1);
    wait_done(base + 1);
    drained("t8");

    repeat (2) @(posedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
